life_grid_scanout: RTL
======================

Name: life_grid_scanout

Overview:
- Downstream consumer of the cell array: snapshots the flattened Status outputs of a ROWS x COLS grid on request and streams them out row by row over a valid/ready handshake, toward the display/UART path.
- Per frame it also computes the live-cell population and flags stable (unchanged since the previous frame) and extinct grids.
- Cells may keep evolving while a frame is being streamed; the snapshot isolates the output from them.

Parameters:
- ROWS, 8, number of grid rows
- COLS, 8, number of grid columns (row width)
- ROW_W, 3, row index width, >= clog2(ROWS)
- CNT_W, 7, population counter width, >= clog2(ROWS*COLS+1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- _rst  input  1  synchronous, active-high reset
- grid_in  input  ROWS*COLS  cell Status vector; bit r*COLS+c = cell (row r, col c)
- start  input  1  single-cycle request to snapshot and stream one frame
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- row_valid  output  1  row_data/row_idx hold a valid row
- row_ready  input  1  consumer accepts the row when row_valid && row_ready
- row_data  output  COLS  snapshot row; bit c = column c
- row_idx  output  ROW_W  index of the row on row_data
- done  output  1  one-cycle pulse after the last row is accepted
- pop_count  output  CNT_W  live cells in the last completed frame
- stable  output  1  last completed frame equals the frame before it
- extinct  output  1  pop_count == 0 for the last completed frame

Behaviour:
- Reset (_rst high at a clk edge): state=IDLE; busy, row_valid, done, stable, extinct=0; pop_count=0; row_idx=0; row_data=0; snapshot, previous-snapshot, running count cleared; have_prev=0. Reset overrides every other input and aborts any frame mid-stream with no done pulse.
- FSM states IDLE, SEND, DONE.
- IDLE:
  - On start=1: snap <= grid_in, row_idx <= 0, running count <= 0, diff <= (grid_in != prev_snap); go to SEND.
  - start at edge N gives row_valid=1 with row 0 at edge N+1.
- SEND:
  - row_valid=1, row_data = snap[row_idx*COLS +: COLS].
  - Outputs are held stable while row_ready=0; no timeout.
  - On row_valid && row_ready: running count += popcount(row_data).
    - If row_idx == ROWS-1: go to DONE.
    - Otherwise row_idx increments.
  - Back-to-back acceptance gives 1 row/cycle; a full frame takes minimum ROWS cycles in SEND.
- DONE (exactly one cycle):
  - done=1, row_valid=0, busy=1.
  - Same edge:
    - pop_count <= running count.
    - extinct <= (running count == 0).
    - stable <= have_prev && !diff.
    - prev_snap <= snap.
    - have_prev <= 1.
  - Next state IDLE. pop_count, stable and extinct hold until the next DONE.
- start while busy (SEND or DONE) is ignored; it is neither queued nor allowed to disturb snap.
- start in IDLE is accepted the same cycle DONE exits, i.e. frames may be requested every ROWS+2 cycles.
- Changes on grid_in after the snapshot edge never affect the frame in flight.
- Counter width: the running count never exceeds ROWS*COLS, so there is no overflow given a legal CNT_W.
- First frame after reset always reports stable=0.

Test Plan:
- Reset mid-frame: start, accept 3 rows, assert _rst one cycle -> row_valid=0, busy=0, no done, pop_count=0, stable=0; next start streams from row_idx 0.
- Blinker on 8x8: grid_in has cells (3,2),(3,3),(3,4) live; start, row_ready=1 constantly -> rows 0..7 on consecutive cycles, row 3 data = 8'b0001_1100, others 0; done on cycle 9 after start; pop_count=3, extinct=0, stable=0.
- Stability: two frames with identical grid_in (block at (1,1),(1,2),(2,1),(2,2)) -> second frame pop_count=4, stable=1. Third frame with cell (5,5) added -> pop_count=5, stable=0.
- Backpressure plus snapshot isolation: row_ready toggles 1,0,0,1,…, and grid_in changes to all-ones after start -> row_data/row_idx held during ready=0; streamed rows equal the pre-change snapshot; pop_count reflects the snapshot.
- Empty grid and ignored start: grid_in=0, start, then pulse start again during SEND -> exactly one frame of 8 zero rows, single done pulse, pop_count=0, extinct=1.
- Full grid: grid_in all ones -> every row_data=8'hFF, pop_count=64, extinct=0.

Source files
------------

// File: rtl/life_grid_scanout.sv
// rtl/life_grid_scanout.sv - snapshot a ROWS x COLS cell grid and stream it out row by row
//
// Purpose:
//   On a start request in IDLE, captures grid_in into a snapshot register, then
//   presents one row per handshake on row_data/row_idx (valid/ready). After the
//   last row is accepted, a one-cycle DONE state publishes the frame population,
//   an extinct flag and a stable flag (frame equals the previous frame).
//
// Ports:
//   clk        in   system clock, rising edge
//   _rst       in   synchronous active-high reset
//   grid_in    in   ROWS*COLS cell status, bit r*COLS+c = (row r, col c)
//   start      in   request one frame (honoured only in IDLE)
//   busy       out  frame in progress (SEND or DONE)
//   row_valid  out  row_data/row_idx valid
//   row_ready  in   consumer accepts the current row
//   row_data   out  snapshot row, bit c = column c
//   row_idx    out  index of the row on row_data
//   done       out  one-cycle pulse after the last row is accepted
//   pop_count  out  live cells in the last completed frame
//   stable     out  last completed frame equals the one before it
//   extinct    out  last completed frame had no live cells

module life_grid_scanout #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ROW_W = 3,
    parameter int CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 _rst,
    input  logic [ROWS*COLS-1:0] grid_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [COLS-1:0]      row_data,
    output logic [ROW_W-1:0]     row_idx,
    output logic                 done,
    output logic [CNT_W-1:0]     pop_count,
    output logic                 stable,
    output logic                 extinct
);

    localparam int GRID_W = ROWS * COLS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [GRID_W-1:0] r_snap;
    logic [GRID_W-1:0] r_prev_snap;
    logic [ROW_W-1:0]  r_row_idx;
    logic [CNT_W-1:0]  r_run_cnt;
    logic [CNT_W-1:0]  r_pop;
    logic              r_diff;
    logic              r_have_prev;
    logic              r_stable;
    logic              r_extinct;

    logic [COLS-1:0]   w_row;
    logic [CNT_W-1:0]  w_row_pop;

    // Row select from the snapshot; a mux over row indices keeps widths explicit.
    always_comb begin
        w_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_row_idx == ROW_W'(r)) begin
                w_row = r_snap[r*COLS +: COLS];
            end
        end
    end

    always_comb begin
        w_row_pop = '0;
        for (int c = 0; c < COLS; c++) begin
            w_row_pop = w_row_pop + CNT_W'(w_row[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (_rst) begin
            r_state     <= S_IDLE;
            r_snap      <= '0;
            r_prev_snap <= '0;
            r_row_idx   <= '0;
            r_run_cnt   <= '0;
            r_pop       <= '0;
            r_diff      <= 1'b0;
            r_have_prev <= 1'b0;
            r_stable    <= 1'b0;
            r_extinct   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snap    <= grid_in;
                        r_row_idx <= '0;
                        r_run_cnt <= '0;
                        // Compare against the previous frame now so prev_snap
                        // can be overwritten freely at DONE.
                        r_diff    <= (grid_in != r_prev_snap);
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (row_ready) begin
                        r_run_cnt <= r_run_cnt + w_row_pop;
                        if (r_row_idx == ROW_W'(ROWS - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_row_idx <= r_row_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_pop       <= r_run_cnt;
                    r_extinct   <= (r_run_cnt == '0);
                    r_stable    <= r_have_prev && !r_diff;
                    r_prev_snap <= r_snap;
                    r_have_prev <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign row_valid = (r_state == S_SEND);
    assign done      = (r_state == S_DONE);
    assign row_data  = (r_state == S_SEND) ? w_row : '0;
    assign row_idx   = r_row_idx;
    assign pop_count = r_pop;
    assign stable    = r_stable;
    assign extinct   = r_extinct;

endmodule
